sparse_row_encoder: RTL
=======================

// Module: sparse_row_encoder
// PURPOSE
//  Producer side of the sparse feature-map format the PE array consumes. Takes a dense
//  8-bit pixel stream one row at a time. Writes that row into the PE input memory:
//  - first a header word {nnz[7:0], 8'h00};
//  - then one word {col_index[7:0], value[7:0]} per non-zero pixel, in column order.
//  Sits between the dense pixel source and the write port of the input-FM memory.
// PARAMETERS
//  ROW_LENGTH  28  pixels per dense row (max 255)
//  NUM_ROWS    28  rows per frame; frame_done fires after this many rows
//  ADDR_WIDTH  4   input-FM memory address width; addresses wrap mod 2^ADDR_WIDTH
//  WORD_WIDTH  16  memory word width; fixed split [15:8] index/count, [7:0] value
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  start       in   1   1-cycle pulse; arms a frame; ignored unless IDLE
//  in_valid    in   1   dense pixel valid
//  in_data     in   8   dense pixel value
//  in_ready    out  1   encoder accepts pixel this cycle
//  mem_we      out  1   write strobe to input-FM memory
//  mem_addr    out  ADDR_WIDTH  write address
//  mem_wdata   out  16  write word (header or entry)
//  row_done    out  1   1-cycle pulse after the last word of a row is written
//  frame_done  out  1   1-cycle pulse after row NUM_ROWS-1 completes
//  busy        out  1   high in every state except IDLE
//  addr_wrap   out  1   sticky; set when any write address wraps past 2^ADDR_WIDTH-1
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; base_addr=0; col=0; nnz=0; row_cnt=0; buffer contents don't-care.
//  Pixel handshake: transfer when in_valid & in_ready. in_ready=1 only in COLLECT.
//  FSM IDLE -> COLLECT on start.
//  COLLECT: on each transfer:
//   - if in_data!=0, write {col,in_data} into row buffer slot nnz and increment nnz;
//   - col increments. Zero pixels consume a column but store nothing.
//   On transfer with col==ROW_LENGTH-1: col<=0, next state HEADER.
//  HEADER (1 cycle): mem_we=1, mem_addr=base_addr, mem_wdata={nnz,8'h00}.
//   If nnz==0 the row finishes this cycle (ROW_END), otherwise go to DRAIN with k=0.
//  DRAIN (nnz cycles): mem_we=1, mem_addr=base_addr+1+k, mem_wdata=buf[k]. ROW_END on k==nnz-1.
//  ROW_END actions (same edge):
//   - base_addr<=base_addr+nnz+1 (mod 2^ADDR_WIDTH); nnz<=0; row_cnt++;
//   - row_done=1 next cycle;
//   - if row_cnt==NUM_ROWS-1 -> IDLE, row_cnt<=0, frame_done=1 together with row_done;
//   - else -> COLLECT.
//  Latency: header written the cycle after the last pixel is accepted.
//   Row cost = ROW_LENGTH+1+nnz cycles at full in_valid.
//  Outputs mem_* are registered; mem_addr/mem_wdata hold their last value when mem_we=0.
//  Widths: nnz 8 bit, saturates impossible since nnz<=ROW_LENGTH<=255. Address adds truncate to ADDR_WIDTH.
//  Wrap: if base_addr+1+k overflows ADDR_WIDTH, write at the wrapped address and set addr_wrap (cleared only by rst).
//  Back-pressure: in_valid low mid-row stalls COLLECT indefinitely; col and nnz hold.
//  start asserted while busy: ignored, no effect on any state.
//  rst mid-row or mid-DRAIN: immediate abort, no further mem_we, partial row abandoned.
// STRUCTURE
//  Package sparse_pkg (shared with PE side): IDX_MSB=15, IDX_LSB=8, VAL_MSB=7, VAL_LSB=0;
//   function make_word(idx,val); FSM state localparams IDLE/COLLECT/HEADER/DRAIN.
//  Sub-module sparse_row_buf: ROW_LENGTH x 16 register array.
//   - 1 sync write port (COLLECT);
//   - 1 async read port indexed by k (DRAIN).
//  Top holds the FSM, counters (col, nnz, k, row_cnt, base_addr) and the registered memory port.
// TESTING
//  1 ROW_LENGTH=28: row with pixels 5 at col 3 and 9 at col 20, rest 0 ->
//    writes addr0=16'h0200, addr1=16'h0305, addr2=16'h1409; row_done 1 cycle later; next base=3.
//  2 All-zero row -> single write 16'h0000 at base; row_done; next base=base+1; no DRAIN cycles.
//  3 Random in_valid gaps (50%) on a row with 4 non-zeros -> memory image identical to the gap-free run;
//    in_ready never high outside COLLECT.
//  4 ADDR_WIDTH=4, base=14, row with 3 non-zeros -> writes at 14,15,0,1; addr_wrap=1 and stays 1.
//  5 NUM_ROWS=2 -> frame_done coincides with the 2nd row_done, busy drops, FSM in IDLE;
//    a start pulse during busy changes nothing.
//  6 Assert rst during DRAIN (k=1 of 3) -> mem_we=0 the same cycle, all outputs 0;
//    a fresh start then encodes from base 0.

Source files
------------

// File: rtl/sparse_row_encoder_pkg.sv
// Shared definitions for the sparse feature-map word format and the encoder FSM.
// Word layout: [15:8] column index or row count, [7:0] pixel value.
package sparse_pkg;

    localparam int IDX_MSB = 15;
    localparam int IDX_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HEADER  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic logic [15:0] make_word(input logic [7:0] idx, input logic [7:0] val);
        logic [15:0] w;
        w = '0;
        w[IDX_MSB:IDX_LSB] = idx;
        w[VAL_MSB:VAL_LSB] = val;
        return w;
    endfunction

endpackage

// File: rtl/sparse_row_encoder_buf.sv
// Row buffer holding the compacted {col, value} entries of the row being encoded.
// Written synchronously while collecting, read combinationally while draining.
module sparse_row_buf #(
    parameter int ROW_LENGTH = 28,
    parameter int IDX_W      = 5,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] slots [ROW_LENGTH];

    always_ff @(posedge clk) begin
        if (we) begin
            slots[waddr] <= wdata;
        end
    end

    assign rdata = slots[raddr];

endmodule

// File: rtl/sparse_row_encoder.sv
// Dense-to-sparse row encoder: collects one dense row, then writes a header word
// {nnz, 0} followed by one {col, value} word per non-zero pixel into the input-FM memory.
module sparse_row_encoder
    import sparse_pkg::*;
#(
    parameter int ROW_LENGTH = 28,
    parameter int NUM_ROWS   = 28,
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  row_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  addr_wrap
);

    localparam int BUF_IDX_W = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
    localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int SUM_W     = ADDR_WIDTH + 9;

    state_t                state, state_d;
    logic [7:0]            col, col_d;
    logic [7:0]            nnz, nnz_d;
    logic [7:0]            k, k_d;
    logic [ROW_W-1:0]      row_cnt, row_cnt_d;
    logic [ADDR_WIDTH-1:0] base_addr, base_addr_d;
    logic                  xfer, row_end, last_row;
    logic                  buf_we;
    logic [WORD_WIDTH-1:0] buf_rdata;
    logic                  we_d, wrap_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WORD_WIDTH-1:0] wdata_d;
    logic [SUM_W-1:0]      drain_sum;

    assign in_ready = (state == COLLECT);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid & in_ready;
    assign buf_we   = xfer && (in_data != 8'd0);
    assign last_row = (row_cnt == ROW_W'(NUM_ROWS - 1));

    sparse_row_buf #(
        .ROW_LENGTH (ROW_LENGTH),
        .IDX_W      (BUF_IDX_W),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (nnz[BUF_IDX_W-1:0]),
        .wdata (make_word(col, in_data)),
        .raddr (k_d[BUF_IDX_W-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d     = state;
        col_d       = col;
        nnz_d       = nnz;
        k_d         = k;
        row_cnt_d   = row_cnt;
        base_addr_d = base_addr;
        row_end     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (xfer) begin
                    if (in_data != 8'd0) nnz_d = nnz + 8'd1;
                    if (col == 8'(ROW_LENGTH - 1)) begin
                        col_d   = 8'd0;
                        state_d = HEADER;
                    end else begin
                        col_d = col + 8'd1;
                    end
                end
            end
            HEADER: begin
                k_d = 8'd0;
                if (nnz == 8'd0) row_end = 1'b1;
                else             state_d = DRAIN;
            end
            DRAIN: begin
                if (k == nnz - 8'd1) row_end = 1'b1;
                else                 k_d = k + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (row_end) begin
            base_addr_d = base_addr + ADDR_WIDTH'(nnz) + ADDR_WIDTH'(1);
            nnz_d       = 8'd0;
            if (last_row) begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end else begin
                state_d   = COLLECT;
                row_cnt_d = row_cnt + ROW_W'(1);
            end
        end
    end

    // Memory port is registered, so its next value follows the state being entered.
    always_comb begin
        drain_sum = SUM_W'(base_addr) + SUM_W'(k_d) + SUM_W'(1);
        we_d      = 1'b0;
        wrap_d    = 1'b0;
        addr_d    = base_addr;
        wdata_d   = make_word(nnz_d, 8'h00);
        if (state_d == HEADER) begin
            we_d = 1'b1;
        end else if (state_d == DRAIN) begin
            we_d    = 1'b1;
            addr_d  = drain_sum[ADDR_WIDTH-1:0];
            wdata_d = buf_rdata;
            wrap_d  = |drain_sum[SUM_W-1:ADDR_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= 8'd0;
            nnz        <= 8'd0;
            k          <= 8'd0;
            row_cnt    <= '0;
            base_addr  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            addr_wrap  <= 1'b0;
        end else begin
            state      <= state_d;
            col        <= col_d;
            nnz        <= nnz_d;
            k          <= k_d;
            row_cnt    <= row_cnt_d;
            base_addr  <= base_addr_d;
            mem_we     <= we_d;
            if (we_d) begin
                mem_addr  <= addr_d;
                mem_wdata <= wdata_d;
            end
            row_done   <= row_end;
            frame_done <= row_end && last_row;
            if (wrap_d) addr_wrap <= 1'b1;
        end
    end

endmodule
